// File: rtl/fetch_unit_pkg.sv
// Shared processor package: fetch sequencer state encoding, the default halt
// instruction word and a saturating counter helper.
package fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    // Instruction word that stops the sequencer; it is never issued to the core
    localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

    // Ceiling of the retired-instruction counter
    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    // Increment that sticks at the ceiling instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == RETIRED_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads one instruction word from instruction
// memory, hands it to the core with a single-cycle run strobe, waits for the
// core to retire it, then advances the PC. A halt instruction word or a halt
// request parks the sequencer until the next start.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int              PC_W       = 8,
    parameter logic [15:0]     HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_valid,
    input  logic            core_done,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     d_instr,
    output logic            run,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e    state_r;
    logic            halt_pend_r;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     d_instr_r;
    logic            run_r;
    logic            mem_req_r;
    logic            busy_r;
    logic            halted_r;
    logic [15:0]     retired_r;

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            halt_pend_r <= 1'b0;
            pc_r        <= RESET_PC;
            d_instr_r   <= 16'h0000;
            run_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
            retired_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    // halt_req is deliberately ignored while parked
                    if (start) begin
                        state_r     <= ST_FETCH;
                        mem_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        halted_r    <= 1'b0;
                        halt_pend_r <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (halt_req) begin
                        halt_pend_r <= 1'b1;
                    end
                    if (mem_valid) begin
                        mem_req_r <= 1'b0;
                        if (mem_rdata == HALT_INSTR) begin
                            // Halt word: keep pc and the last issued instruction
                            state_r  <= ST_HALTED;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                        end else begin
                            state_r   <= ST_ISSUE;
                            d_instr_r <= mem_rdata;
                            run_r     <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    // run was raised on entry; it lasts exactly this one cycle
                    if (halt_req) begin
                        halt_pend_r <= 1'b1;
                    end
                    run_r   <= 1'b0;
                    state_r <= ST_EXEC;
                end

                ST_EXEC: begin
                    if (core_done) begin
                        pc_r      <= pc_r + PC_ONE;
                        retired_r <= sat_inc16(retired_r);
                        // A halt_req coinciding with core_done still counts as pending
                        if (halt_pend_r || halt_req) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            halt_pend_r <= 1'b0;
                        end else begin
                            state_r   <= ST_FETCH;
                            mem_req_r <= 1'b1;
                        end
                    end else if (halt_req) begin
                        halt_pend_r <= 1'b1;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    halt_pend_r <= 1'b0;
                    run_r       <= 1'b0;
                    mem_req_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = pc_r;
    assign d_instr  = d_instr_r;
    assign run      = run_r;
    assign pc       = pc_r;
    assign busy     = busy_r;
    assign halted   = halted_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory and core responders with
// randomized latencies, a transaction-level model of pc / retired count, and a
// linear sequence of directed scenarios.
module tb_fetch_unit;

    localparam logic [15:0] HALT = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        core_done;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] d_instr;
    logic        run;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt_req  (halt_req),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .core_done (core_done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .d_instr   (d_instr),
        .run       (run),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    // Free-running clock, first rising edge at 5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];
    int          checks = 0;
    int          passed = 0;
    int          run_count = 0;
    int          req_count = 0;
    logic [7:0]  exp_pc = 8'h00;
    logic [15:0] exp_retired = 16'h0000;
    int          mem_lat = 1;
    int          core_lat = 4;
    bit          core_auto = 1'b1;
    bit          halt_with_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic fill_mem();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i] = (v[15:0] == HALT) ? 16'h0000 : v[15:0];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "-pc"},      {24'h0, pc},      32'h0);
        check({tag, "-mem_addr"},{24'h0, mem_addr},32'h0);
        check({tag, "-d_instr"}, {16'h0, d_instr}, 32'h0);
        check({tag, "-run"},     {31'h0, run},     32'h0);
        check({tag, "-mem_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "-busy"},    {31'h0, busy},    32'h0);
        check({tag, "-halted"},  {31'h0, halted},  32'h0);
        check({tag, "-retired"}, {16'h0, retired}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        halt_req = 1'b0;
        exp_pc = 8'h00;
        exp_retired = 16'h0000;
        run_count = 0;
        req_count = 0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Instruction memory: answers each request after mem_lat cycles (random 1..4 when 0)
    initial begin
        bit         m_busy = 1'b0;
        int         m_cnt = 0;
        logic [7:0] m_addr = 8'h00;
        forever begin
            step();
            if (reset) begin
                m_busy = 1'b0;
                mem_valid = 1'b0;
            end else begin
                if (mem_valid) begin
                    mem_valid = 1'b0;
                end else if (mem_req && !m_busy) begin
                    m_busy = 1'b1;
                    m_cnt = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
                    m_addr = mem_addr;
                    req_count++;
                    check("req-addr", {24'h0, mem_addr}, {24'h0, exp_pc});
                end
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = mem[m_addr];
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Core: on each run pulse checks the issued word, retires it after core_lat cycles
    initial begin
        bit c_busy = 1'b0;
        bit c_fired = 1'b0;
        bit c_halt = 1'b0;
        bit prev_run = 1'b0;
        int c_cnt = 0;
        forever begin
            step();
            if (prev_run) check("run-width", {31'h0, run}, 32'h0);
            prev_run = run;
            if (c_fired) begin
                core_done = 1'b0;
                c_fired = 1'b0;
            end
            if (c_halt) begin
                halt_req = 1'b0;
                c_halt = 1'b0;
            end
            if (reset) begin
                c_busy = 1'b0;
            end else if (run) begin
                run_count++;
                check("run-d_instr", {16'h0, d_instr}, {16'h0, mem[exp_pc]});
                if (core_auto) begin
                    c_busy = 1'b1;
                    c_cnt = (core_lat == 0) ? int'($urandom_range(4, 1)) : core_lat;
                end
            end else if (c_busy) begin
                c_cnt--;
                if (c_cnt == 0) begin
                    core_done = 1'b1;
                    c_fired = 1'b1;
                    c_busy = 1'b0;
                    exp_pc = exp_pc + 8'd1;
                    if (exp_retired != 16'hFFFF) exp_retired = exp_retired + 16'd1;
                    if (halt_with_done) begin
                        halt_req = 1'b1;
                        c_halt = 1'b1;
                    end
                end
            end
        end
    end

    // Directed scenario sequence
    initial begin
        int rc;
        int h;
        int req_cycles;
        reset = 1'b1; start = 1'b0; halt_req = 1'b0;
        mem_rdata = 16'h0000; mem_valid = 1'b0; core_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset acts before any clock edge
        #3;
        check_idle_outputs("por");
        step(); step();
        reset = 1'b0;
        step();

        // Single instruction: latency-1 memory, core_done 4 cycles after run
        fill_mem();
        mem[0] = 16'h1234;
        mem[3] = HALT;
        mem_lat = 1; core_lat = 4;
        pulse_start();
        for (int i = 0; i < 100 && retired != 16'd1; i++) step();
        check("t1-retired", {16'h0, retired}, 32'd1);
        check("t1-runs", run_count, 32'd1);
        check("t1-d_instr", {16'h0, d_instr}, 32'h1234);
        check("t1-pc", {24'h0, pc}, 32'd1);
        check("t1-busy", {31'h0, busy}, 32'd1);
        check("t1-mem_req", {31'h0, mem_req}, 32'd1);
        check("t1-mem_addr", {24'h0, mem_addr}, 32'd1);

        // Halt word at address 3
        for (int i = 0; i < 200 && !halted; i++) step();
        check("t2-halted", {31'h0, halted}, 32'd1);
        check("t2-pc", {24'h0, pc}, 32'd3);
        check("t2-retired", {16'h0, retired}, 32'd3);
        check("t2-busy", {31'h0, busy}, 32'd0);
        check("t2-d_instr", {16'h0, d_instr}, {16'h0, mem[2]});
        repeat (5) step();
        check("t2-runs", run_count, 32'd3);
        rc = req_count;
        pulse_start();
        check("t2-restart-halted", {31'h0, halted}, 32'd0);
        for (int i = 0; i < 50 && !halted; i++) step();
        check("t2-refetch-halted", {31'h0, halted}, 32'd1);
        check("t2-refetch-reqs", req_count, rc + 1);
        check("t2-refetch-pc", {24'h0, pc}, 32'd3);
        check("t2-refetch-runs", run_count, 32'd3);

        // halt_req during EXEC of address 5
        mem[3] = 16'h0003;
        core_lat = 4;
        pulse_start();
        for (int i = 0; i < 200 && run_count != 6; i++) step();
        check("t3-runs-reached", run_count, 32'd6);
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int i = 0; i < 100 && busy; i++) step();
        check("t3-busy", {31'h0, busy}, 32'd0);
        check("t3-pc", {24'h0, pc}, 32'd6);
        check("t3-retired", {16'h0, retired}, 32'd6);
        check("t3-halted", {31'h0, halted}, 32'd0);
        rc = req_count;
        repeat (8) step();
        check("t3-no-fetch", req_count, rc);
        check("t3-mem_req", {31'h0, mem_req}, 32'd0);

        // halt_req coinciding with core_done
        halt_with_done = 1'b1;
        core_lat = 2;
        pulse_start();
        for (int i = 0; i < 100 && busy; i++) step();
        halt_with_done = 1'b0;
        check("t4-busy", {31'h0, busy}, 32'd0);
        check("t4-pc", {24'h0, pc}, 32'd7);
        check("t4-retired", {16'h0, retired}, 32'd7);
        check("t4-runs", run_count, 32'd7);
        check("t4-halted", {31'h0, halted}, 32'd0);

        // Random latencies and data across the PC wrap, halting at address 2
        fill_mem();
        mem[2] = HALT;
        mem_lat = 0; core_lat = 0;
        pulse_start();
        for (int i = 0; i < 6000 && pc != 8'hFF; i++) step();
        check("t5-reach-ff", {24'h0, pc}, 32'hFF);
        for (int i = 0; i < 100 && pc == 8'hFF; i++) step();
        check("t5-wrap-pc", {24'h0, pc}, 32'h0);
        check("t5-wrap-busy", {31'h0, busy}, 32'd1);
        check("t5-wrap-mem_addr", {24'h0, mem_addr}, 32'h0);
        check("t5-wrap-retired", {16'h0, retired}, 32'd256);
        for (int i = 0; i < 300 && !halted; i++) step();
        check("t5-halted", {31'h0, halted}, 32'd1);
        check("t5-pc", {24'h0, pc}, 32'd2);
        check("t5-retired", {16'h0, retired}, 32'd258);
        check("t5-retired-model", {16'h0, retired}, {16'h0, exp_retired});
        check("t5-runs", run_count, 32'd258);

        // Random short programs from reset
        for (int k = 0; k < 3; k++) begin
            do_reset();
            fill_mem();
            h = int'($urandom_range(12, 1));
            mem[h] = HALT;
            pulse_start();
            for (int i = 0; i < 400 && !halted; i++) step();
            check("t6-halted", {31'h0, halted}, 32'd1);
            check("t6-pc", {24'h0, pc}, h);
            check("t6-retired", {16'h0, retired}, h);
            check("t6-runs", run_count, h);
        end

        // Latency-5 memory with start pulsed during FETCH
        do_reset();
        fill_mem();
        mem[1] = HALT;
        mem_lat = 5; core_lat = 2;
        pulse_start();
        req_cycles = 0;
        for (int i = 0; i < 20 && mem_req; i++) begin
            req_cycles++;
            start = (req_cycles == 2);
            step();
        end
        start = 1'b0;
        check("t7-req-cycles", req_cycles, 32'd5);
        for (int i = 0; i < 100 && !halted; i++) step();
        check("t7-halted", {31'h0, halted}, 32'd1);
        check("t7-runs", run_count, 32'd1);
        check("t7-pc", {24'h0, pc}, 32'd1);
        check("t7-retired", {16'h0, retired}, 32'd1);

        // Reset during EXEC, then late core_done and stray mem_valid
        do_reset();
        fill_mem();
        mem_lat = 1; core_lat = 1; core_auto = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && run_count != 1; i++) step();
        step(); step();
        check("t8-exec-busy", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_idle_outputs("t8-async");
        step();
        reset = 1'b0;
        exp_pc = 8'h00; exp_retired = 16'h0000;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'hABCD;
        step();
        mem_valid = 1'b0;
        step();
        check_idle_outputs("t8-late");
        core_auto = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
